// File: rtl/tdm_voice_sequencer_pkg.sv
// Shared definitions for the TDM voice sequencer: config opcodes, default
// widths and the power-on phase offset of each voice.
package synth_voice_pkg;

  typedef enum logic [1:0] {
    OP_SET_INCR   = 2'd0,
    OP_SET_OFFSET = 2'd1,
    OP_GATE_ON    = 2'd2,
    OP_GATE_OFF   = 2'd3
  } cfg_op_t;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;

  // Voices come out of reset spread across the table in reverse order.
  function automatic int reset_offset(input int num_voices, input int voice);
    return num_voices - 1 - voice;
  endfunction

endpackage

// File: rtl/tdm_voice_regfile.sv
// Per-voice phase state with a config write port, an accumulator-only step
// write port and a combinational read port.
module tdm_voice_regfile
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int VW         = $clog2(NUM_VOICES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_op,
  input  logic [VW-1:0]     cfg_voice,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ADDR_W-1:0] cfg_offset,
  input  logic              step_we,
  input  logic [VW-1:0]     step_voice,
  input  logic [ACC_W-1:0]  step_acc,
  input  logic [VW-1:0]     rd_voice,
  output logic [ACC_W-1:0]  rd_acc,
  output logic [ACC_W-1:0]  rd_incr,
  output logic [ADDR_W-1:0] rd_offset,
  output logic              rd_gate
);

  logic [ACC_W-1:0]  acc_r    [NUM_VOICES];
  logic [ACC_W-1:0]  incr_r   [NUM_VOICES];
  logic [ADDR_W-1:0] offset_r [NUM_VOICES];
  logic              gate_r   [NUM_VOICES];

  // State update; config and step writes are never enabled in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        acc_r[v]    <= {ACC_W{1'b0}};
        incr_r[v]   <= {ACC_W{1'b0}};
        offset_r[v] <= ADDR_W'(reset_offset(NUM_VOICES, v));
        gate_r[v]   <= 1'b0;
      end
    end else if (cfg_we) begin
      case (cfg_op_t'(cfg_op))
        OP_SET_INCR:   incr_r[cfg_voice]   <= cfg_incr;
        OP_SET_OFFSET: offset_r[cfg_voice] <= cfg_offset;
        OP_GATE_ON: begin
          gate_r[cfg_voice] <= 1'b1;
          acc_r[cfg_voice]  <= {ACC_W{1'b0}};
        end
        OP_GATE_OFF:   gate_r[cfg_voice]   <= 1'b0;
        default: begin
          gate_r[cfg_voice] <= gate_r[cfg_voice];
        end
      endcase
    end else if (step_we) begin
      acc_r[step_voice] <= step_acc;
    end
  end

  // Read port for the voice currently owning the slot.
  always_comb begin
    rd_acc    = acc_r[rd_voice];
    rd_incr   = incr_r[rd_voice];
    rd_offset = offset_r[rd_voice];
    rd_gate   = gate_r[rd_voice];
  end

endmodule

// File: rtl/tdm_voice_sequencer.sv
// Time-multiplexed phase-accumulator engine: one shared adder steps every
// voice in round-robin, two cycles per voice (config phase, step phase).
module tdm_voice_sequencer
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int VW         = $clog2(NUM_VOICES)
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_op,
  input  logic [VW-1:0]     cfg_voice,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ADDR_W-1:0] cfg_offset,
  output logic [ADDR_W-1:0] tdm_addr,
  output logic [VW-1:0]     tdm_voice,
  output logic              tdm_active,
  output logic              tdm_valid,
  output logic              frame_start
);

  logic              phase_r;
  logic [VW-1:0]     slot_r;
  logic              cfg_we_s;
  logic              step_we_s;
  logic [ACC_W-1:0]  step_acc_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic [ACC_W-1:0]  rd_acc_s;
  logic [ACC_W-1:0]  rd_incr_s;
  logic [ADDR_W-1:0] rd_offset_s;
  logic              rd_gate_s;

  // Ready is gated by reset so it reads 0 for the whole reset interval.
  assign cfg_ready = rst_n & ~phase_r;
  assign cfg_we_s  = cfg_valid & cfg_ready;

  tdm_voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .ACC_W      (ACC_W),
    .ADDR_W     (ADDR_W),
    .VW         (VW)
  ) u_regfile (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we_s),
    .cfg_op     (cfg_op),
    .cfg_voice  (cfg_voice),
    .cfg_incr   (cfg_incr),
    .cfg_offset (cfg_offset),
    .step_we    (step_we_s),
    .step_voice (slot_r),
    .step_acc   (step_acc_s),
    .rd_voice   (slot_r),
    .rd_acc     (rd_acc_s),
    .rd_incr    (rd_incr_s),
    .rd_offset  (rd_offset_s),
    .rd_gate    (rd_gate_s)
  );

  // Shared adder and wavetable address for the voice in its step phase.
  always_comb begin
    step_we_s   = 1'b0;
    step_acc_s  = rd_acc_s;
    addr_next_s = rd_offset_s;
    if (phase_r && rd_gate_s) begin
      step_we_s   = 1'b1;
      step_acc_s  = rd_acc_s + rd_incr_s;
      addr_next_s = rd_acc_s[ACC_W-1 -: ADDR_W] + rd_offset_s;
    end else begin
      step_we_s   = 1'b0;
      step_acc_s  = rd_acc_s;
      addr_next_s = rd_offset_s;
    end
  end

  // Slot/phase sequencer: the slot advances after its step phase.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      slot_r  <= {VW{1'b0}};
    end else begin
      phase_r <= ~phase_r;
      if (phase_r) begin
        slot_r <= slot_r + VW'(1'b1);
      end
    end
  end

  // Output registers: loaded in the step phase, strobes cleared otherwise.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tdm_addr    <= {ADDR_W{1'b0}};
      tdm_voice   <= {VW{1'b0}};
      tdm_active  <= 1'b0;
      tdm_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (phase_r) begin
      tdm_addr    <= addr_next_s;
      tdm_voice   <= slot_r;
      tdm_active  <= rd_gate_s;
      tdm_valid   <= 1'b1;
      frame_start <= (slot_r == {VW{1'b0}});
    end else begin
      tdm_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_voice_sequencer.sv
// Directed bench for tdm_voice_sequencer: a reset/idle vector table plus
// hand-written sequences for ramps, gating, stalls and mid-frame reset.
module tb_tdm_voice_sequencer;
  import synth_voice_pkg::*;

  localparam int NV = 8;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int VW = 3;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_op = 2'd0;
  logic [VW-1:0] cfg_voice = 3'd0;
  logic [AW-1:0] cfg_incr = 24'd0;
  logic [DW-1:0] cfg_offset = 8'd0;
  logic [DW-1:0] tdm_addr;
  logic [VW-1:0] tdm_voice;
  logic          tdm_active;
  logic          tdm_valid;
  logic          frame_start;

  int errors = 0;
  int checks = 0;

  tdm_voice_sequencer #(.NUM_VOICES(NV), .ACC_W(AW), .ADDR_W(DW)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_op      (cfg_op),
    .cfg_voice   (cfg_voice),
    .cfg_incr    (cfg_incr),
    .cfg_offset  (cfg_offset),
    .tdm_addr    (tdm_addr),
    .tdm_voice   (tdm_voice),
    .tdm_active  (tdm_active),
    .tdm_valid   (tdm_valid),
    .frame_start (frame_start)
  );

  always #5 sys_clk = ~sys_clk;

  // exp packs {cfg_ready, tdm_valid, tdm_voice, tdm_addr, tdm_active, frame_start}
  typedef struct {
    logic        rst;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_table();
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      rst_n = vecs[i].rst;
      #1;
      check($sformatf("reset_vec%0d", i),
            {17'd0, cfg_ready, tdm_valid, tdm_voice, tdm_addr, tdm_active, frame_start},
            {17'd0, vecs[i].exp});
    end
  endtask

  task automatic wait_slot(input int v);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge sys_clk);
      if (tdm_valid && (tdm_voice == 3'(v))) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_slot%0d: no strobe within 40 cycles, expected one", v);
    end
  endtask

  task automatic expect_voice(input int v, input logic [7:0] addr, input logic active, input string name);
    wait_slot(v);
    check(name, {23'd0, tdm_active, tdm_addr}, {23'd0, active, addr});
  endtask

  task automatic cfg_write(input logic [1:0] op, input int v, input logic [23:0] inc, input logic [7:0] off);
    int n;
    n = 0;
    @(negedge sys_clk);
    cfg_valid = 1'b1;
    cfg_op = op;
    cfg_voice = 3'(v);
    cfg_incr = inc;
    cfg_offset = off;
    #1;
    while (!cfg_ready && n < 4) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL cfg_accept: ready=0 expected 1");
    end
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 15'd0};
    vecs[1] = '{1'b1, {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0}};
    vecs[2] = '{1'b1, 15'd0};
    for (int j = 0; j < 8; j++) begin
      vecs[3 + 2*j] = '{1'b1, {1'b1, 1'b1, 3'(j), 8'(7 - j), 1'b0, (j == 0)}};
      vecs[4 + 2*j] = '{1'b1, {1'b0, 1'b0, 3'(j), 8'(7 - j), 1'b0, 1'b0}};
    end
    vecs[19] = '{1'b1, {1'b1, 1'b1, 3'd0, 8'd7, 1'b0, 1'b1}};

    repeat (3) @(posedge sys_clk);
    apply_table();

    // Voice 2 ramp: one address step per frame, wrapping 255 -> 0.
    cfg_write(OP_SET_INCR, 2, 24'h010000, 8'd0);
    cfg_write(OP_GATE_ON, 2, 24'd0, 8'd0);
    for (int k = 0; k < 258; k++) begin
      expect_voice(2, 8'((5 + k) % 256), 1'b1, $sformatf("v2_ramp%0d", k));
    end

    // Voice 0 at half-table increment alternates 0x00 / 0x80.
    cfg_write(OP_SET_OFFSET, 0, 24'd0, 8'd0);
    cfg_write(OP_SET_INCR, 0, 24'h800000, 8'd0);
    cfg_write(OP_GATE_ON, 0, 24'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      expect_voice(0, (k % 2 == 0) ? 8'h00 : 8'h80, 1'b1, $sformatf("v0_alt%0d", k));
    end

    // Voice 3: run, gate off inside its own slot, then restart.
    cfg_write(OP_SET_INCR, 3, 24'h030000, 8'd0);
    cfg_write(OP_GATE_ON, 3, 24'd0, 8'd0);
    expect_voice(3, 8'd4, 1'b1, "v3_run0");
    expect_voice(3, 8'd7, 1'b1, "v3_run1");
    wait_slot(2);
    cfg_valid = 1'b1;
    cfg_op = OP_GATE_OFF;
    cfg_voice = 3'd3;
    #1;
    check("gateoff_ready", {31'd0, cfg_ready}, 32'd1);
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    expect_voice(3, 8'd4, 1'b0, "gateoff_same_slot");
    expect_voice(3, 8'd4, 1'b0, "gateoff_hold");
    cfg_write(OP_GATE_ON, 3, 24'd0, 8'd0);
    expect_voice(3, 8'd4, 1'b1, "regate_restart");
    expect_voice(3, 8'd7, 1'b1, "regate_step");

    // Request raised in phase 1 stalls exactly one cycle.
    wait_slot(1);
    @(negedge sys_clk);
    cfg_valid = 1'b1;
    cfg_op = OP_SET_OFFSET;
    cfg_voice = 3'd5;
    cfg_offset = 8'h40;
    #1;
    check("stall_ready_low", {31'd0, cfg_ready}, 32'd0);
    @(negedge sys_clk);
    #1;
    check("stall_ready_high", {31'd0, cfg_ready}, 32'd1);
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    expect_voice(5, 8'h40, 1'b0, "stall_write");

    // Mid-frame reset with voices gated, then a clean first frame.
    wait_slot(4);
    @(posedge sys_clk);
    apply_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_voice_sequencer.md
# tdm_voice_sequencer

Parametrised, time-multiplexed phase-accumulator engine for the poly synth. Replaces per-voice divider counters with one shared adder that steps `NUM_VOICES` fractional phase accumulators in round-robin, two clock cycles per voice. Emits one wavetable BRAM address per voice slot, plus voice index and gate status for the downstream mixer. Voice frequency, phase offset and gate are programmed at runtime through a valid/ready config port.

## Interface
Parameters:
- `NUM_VOICES`, 8: voice count; power of two, 2 to 32.
- `ACC_W`, 24: phase accumulator and increment width.
- `ADDR_W`, 8: wavetable address width; must satisfy `ADDR_W` ≤ `ACC_W`.
- `VW`, `$clog2(NUM_VOICES)`: voice index width (derived).

Ports:
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accepted when both `cfg_valid` and `cfg_ready` are high.
- `cfg_op` in 2: operation code.
  - 0: SET_INCR
  - 1: SET_OFFSET
  - 2: GATE_ON
  - 3: GATE_OFF
- `cfg_voice` in `VW`: target voice.
- `cfg_incr` in `ACC_W`: increment value, used by SET_INCR.
- `cfg_offset` in `ADDR_W`: phase offset, used by SET_OFFSET.
- `tdm_addr` out `ADDR_W`: wavetable address for the current slot.
- `tdm_voice` out `VW`: voice index belonging to `tdm_addr`.
- `tdm_active` out 1: gate state of that voice.
- `tdm_valid` out 1: one-cycle strobe marking new `tdm_*` outputs.
- `frame_start` out 1: high together with `tdm_valid` when `tdm_voice` = 0.

## Operation
Per-voice state:
- `acc[ACC_W]`: phase accumulator.
- `incr[ACC_W]`: phase increment.
- `offset[ADDR_W]`: phase offset.
- `gate`: voice on/off.

Reset values:
- `acc` = 0, `incr` = 0, `gate` = 0.
- `offset[v]` = `NUM_VOICES-1-v`.

Sequencing:
- `slot` counter (`VW` bits) and a 1-bit `phase` toggle, both 0 at reset.
- `phase` toggles every cycle; `slot` increments (wrapping) when `phase` = 1.

Phase 0 (config):
- `cfg_ready` = 1 only in phase 0; it is 0 while `rst_n` = 0.
- An accepted op updates the target voice at the end of the cycle:
  - SET_INCR: `incr` ← `cfg_incr`.
  - SET_OFFSET: `offset` ← `cfg_offset`.
  - GATE_ON: `gate` ← 1, `acc` ← 0 (phase restart, including a voice that is already gated).
  - GATE_OFF: `gate` ← 0; `acc` keeps its value.

Phase 1 (step), for voice `v` = `slot`, reading the state after any phase-0 write:
- If `gate`:
  - `tdm_addr` ← `acc[ACC_W-1 -: ADDR_W]` + `offset`, modulo 2^`ADDR_W`.
  - `acc` ← `acc` + `incr`, modulo 2^`ACC_W`; wrap is silent.
- If not `gate`:
  - `tdm_addr` ← `offset`.
  - `acc` unchanged.
- Also registered: `tdm_voice` ← `v`, `tdm_active` ← `gate`, `tdm_valid` ← 1, `frame_start` ← (`v` = 0).

Other behaviour:
- `incr` = 0 with `gate` = 1 holds the phase constant.
- A write aimed at the voice currently in its slot takes effect in that same slot; config writes and the accumulator step never share a cycle.
- Output sample rate per voice = f(`sys_clk`) / (2·`NUM_VOICES`).

## Timing
- Reset:
  - Every output is 0 while `rst_n` = 0, including `cfg_ready`.
  - Reset asserted mid-frame clears all state and outputs immediately (asynchronously).
- After `rst_n` rises:
  - Edge 1 executes phase 0 of slot 0.
  - Edge 2 registers the slot-0 outputs, so `tdm_valid` = `frame_start` = 1 during cycle 2.
- `tdm_valid` pulses once every 2 cycles; outputs hold between pulses.
- Config latency: a write accepted at edge N affects the `tdm_addr` produced at edge N+1 if it targets the current slot; otherwise it affects that voice's next slot.
- Requests presented in phase 1 stall one cycle. `cfg_*` fields must be held stable until accepted.

## Structure
- Package `synth_voice_pkg` holds:
  - `cfg_op` encodings (SET_INCR, SET_OFFSET, GATE_ON, GATE_OFF).
  - Default `ACC_W` and `ADDR_W`.
  - The reset-offset rule.
- Sub-module `tdm_voice_regfile`:
  - Per-voice `acc`/`incr`/`offset`/`gate` arrays.
  - One config write port, one step write port (`acc` only), one combinational read port indexed by `slot`.
- The top level contains the slot/phase sequencer, the adder and the output registers.

## Test plan
All scenarios use `NUM_VOICES`=8, `ACC_W`=24, `ADDR_W`=8.
- Reset, then idle 16 cycles:
  - `cfg_ready` = 1 only in phase 0.
  - `tdm_voice` sequence is 0..7 with `tdm_addr` = 7..0 and `tdm_active` = 0.
  - `frame_start` is high only for voice 0.
- SET_INCR voice 2 = 0x010000, then GATE_ON voice 2:
  - Voice 2 `tdm_addr` over successive frames is 5, 6, 7, …
  - It wraps 255 → 0 after 256 frames.
- Voice 0 with `incr` = 0x800000 and `offset` 0: `tdm_addr` alternates 0x00, 0x80 each frame.
- GATE_OFF voice 3 in phase 0 of slot 3 while it is running:
  - That same slot shows `tdm_active` = 0 and `tdm_addr` = `offset`.
  - GATE_ON later restarts the voice at `offset`.
- Hold `cfg_valid` from a phase-1 cycle: `cfg_ready` = 0 that cycle; the request is accepted exactly one cycle later, with one write only.
- Assert `rst_n` low mid-frame with voices gated:
  - All outputs are 0 immediately.
  - After release, the first-frame outputs match the reset scenario.
